cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Two-requester memory arbiter/sequencer between the I-cache refill port and the D-cache refill/writeback port, which feeds the LSU's `cache_rvalid`/`cache_rdata`.
- Shares the single burst memory port (address, write-data, read-data and write-response channels).
- Grants one transaction at a time with round-robin priority and sequences its phases.
- Routes read beats and the write completion back to the owner.

Parameters:
- AW, 64, address width
- DW, 64, data width (bytes per beat = DW/8)
- LENW, 8, burst length field width (value = beats-1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  I-cache read request
- i_req_ready  out  1  I-cache request accepted
- i_req_addr  in  AW  I-cache burst start address
- i_req_len  in  LENW  I-cache beats-1
- i_rvalid  out  1  read beat to I-cache
- i_rlast  out  1  final I-cache beat
- d_req_valid  in  1  D-cache request
- d_req_ready  out  1  D-cache request accepted
- d_req_we  in  1  1=write burst, 0=read burst
- d_req_addr  in  AW  D-cache burst start address
- d_req_len  in  LENW  D-cache beats-1
- d_wvalid  in  1  D-cache write beat valid
- d_wready  out  1  D-cache write beat accepted
- d_wdata  in  DW  write beat data
- d_wstrb  in  DW/8  write byte strobes
- d_rvalid  out  1  read beat to D-cache
- d_rlast  out  1  final D-cache beat
- d_bvalid  out  1  D-cache write complete, 1-cycle pulse
- rdata  out  DW  shared read beat data (qualify with i_rvalid/d_rvalid)
- mem_avalid  out  1  memory address phase valid
- mem_aready  in  1  memory address accepted
- mem_we  out  1  transaction is write
- mem_addr  out  AW  burst address
- mem_len  out  LENW  beats-1
- mem_wvalid  out  1  write beat valid
- mem_wready  in  1  memory accepts write beat
- mem_wdata  out  DW  write beat data
- mem_wstrb  out  DW/8  write strobes
- mem_wlast  out  1  final write beat
- mem_rvalid  in  1  read beat (no backpressure)
- mem_rdata  in  DW  read beat data
- mem_rlast  in  1  final read beat
- mem_bvalid  in  1  write response

Behaviour:
- States:
  - IDLE: choose grant.
  - ADDR: hold mem_avalid until mem_aready. Next state is WDATA if we, else RDATA.
  - WDATA: pass D write beats; count down a beat counter loaded from len. The beat with count==0 drives mem_wlast. Handshake on that beat goes to BRESP.
  - RDATA: route mem_rvalid/mem_rdata to the owner. mem_rlast goes to IDLE.
  - BRESP: wait mem_bvalid, pulse d_bvalid in the same cycle (combinational), then go to IDLE.
- Arbitration, in IDLE only:
  - One valid requester: grant it.
  - Both valid: grant the one not granted last. The last-grant register resets to I, so the first contention grants D.
  - Request accept: {x}_req_ready=1 combinationally for the granted side in IDLE. On that cycle, latch owner, we (I forced 0), addr and len into registers, and go to ADDR next cycle.
  - The non-granted requester sees ready=0 and must hold its request stable.
- Memory address outputs are driven from latched registers only, so they are stable while mem_avalid=1.
- Latency: request accept to mem_avalid is 1 cycle.
- Write path in WDATA:
  - mem_wvalid=d_wvalid; d_wready=mem_wready.
  - wdata and wstrb pass through combinationally.
  - Counter decrements on each beat handshake.
- Read path: i_rvalid/d_rvalid = mem_rvalid & (state==RDATA) & owner match; rdata=mem_rdata; {x}_rlast=mem_rlast qualified identically.
- Error guards:
  - mem_rvalid outside RDATA and mem_bvalid outside BRESP are ignored.
  - mem_rlast arriving before the counted length still ends the burst.
- Reset (rst=0, any state, including mid-burst):
  - State goes to IDLE and last-grant to I; counter and latched fields clear to 0.
  - All outputs deassert: ready, valid and last signals 0; mem_addr/mem_len/mem_we 0.
  - An in-flight memory transaction is abandoned. The memory side is reset by the same rst.
- Len 0 (single beat): WDATA emits one beat with mem_wlast=1.
- Max burst: len=2^LENW-1.

Decomposition:
- Shared package holds:
  - the arb state enum (IDLE, ADDR, WDATA, RDATA, BRESP)
  - owner encoding (OWN_I=0, OWN_D=1)
  - default widths AW/DW/LENW.
- One natural sub-module: rr_arb2, the 2-way round-robin picker with a last-grant register that updates on accept. The rest stays in the top module.

Test Plan:
- I read, len=3, addr=0x8000_0000; memory returns 4 beats 0x11..0x44 -> i_rvalid on 4 cycles with matching rdata, i_rlast on beat 4, d_rvalid=0 throughout, back to IDLE.
- Both request in the same cycle after reset -> D granted first (d_req_ready=1, i_req_ready=0); I granted on the next IDLE. Then two more simultaneous requests -> grants alternate D, I, D, I.
- D write, len=1, wdata 0xAAAA/0xBBBB, mem_wready low for 2 cycles on beat 1 -> beat held stable, mem_wlast only on beat 2, d_bvalid pulse exactly when mem_bvalid=1.
- mem_aready held low 5 cycles -> mem_avalid/addr/len stable all 5 cycles; new d_req_valid not accepted until the current transaction completes.
- rst asserted low mid-RDATA after beat 2 of 4 -> all outputs 0 asynchronously. After release, an I request len=0 completes normally.
- Stray mem_rvalid=1 in IDLE -> no i_rvalid/d_rvalid asserted.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and default widths for the I/D cache refill memory arbiter.
package cache_mem_arbiter_pkg;

  localparam int AW_DEF   = 64;
  localparam int DW_DEF   = 64;
  localparam int LENW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_BRESP = 3'd4
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last accepted grant and favours
// the other side when both request at once.
module rr_arb2
  import cache_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic accept,
  output logic gnt_valid,
  output logic gnt_d
);

  logic last_r;

  // Pick a winner from the current requests and the last grant.
  always_comb begin
    gnt_valid = req_i | req_d;
    if (req_i && req_d) begin
      gnt_d = (last_r == OWN_I);
    end else if (req_d) begin
      gnt_d = 1'b1;
    end else begin
      gnt_d = 1'b0;
    end
  end

  // Last-grant register, updated only when the grant is actually taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= OWN_I;
    end else if (accept) begin
      last_r <= gnt_d;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between the I-cache refill and D-cache
// refill/writeback ports, one transaction at a time.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [LENW-1:0] i_req_len,
  output logic            i_rvalid,
  output logic            i_rlast,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic            d_req_we,
  input  logic [AW-1:0]   d_req_addr,
  input  logic [LENW-1:0] d_req_len,
  input  logic            d_wvalid,
  output logic            d_wready,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_rvalid,
  output logic            d_rlast,
  output logic            d_bvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_avalid,
  input  logic            mem_aready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [LENW-1:0] mem_len,
  output logic            mem_wvalid,
  input  logic            mem_wready,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  output logic            mem_wlast,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_rlast,
  input  logic            mem_bvalid
);

  arb_state_e      state_r, state_nxt_s;
  logic            owner_r;
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [LENW-1:0] len_r;
  logic [LENW-1:0] cnt_r;
  logic            gnt_valid_s;
  logic            gnt_d_s;
  logic            accept_s;
  logic            wbeat_s;
  logic            rd_active_s;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (i_req_valid),
    .req_d     (d_req_valid),
    .accept    (accept_s),
    .gnt_valid (gnt_valid_s),
    .gnt_d     (gnt_d_s)
  );

  // Gating with rst keeps ready low while reset is held, even in IDLE.
  assign accept_s = rst & (state_r == ST_IDLE) & gnt_valid_s;
  assign wbeat_s  = (state_r == ST_WDATA) & d_wvalid & mem_wready;

  // Next-state and per-phase handshake outputs.
  always_comb begin
    state_nxt_s = state_r;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    mem_avalid  = 1'b0;
    mem_wvalid  = 1'b0;
    d_wready    = 1'b0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    mem_wlast   = 1'b0;
    d_bvalid    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          d_req_ready = gnt_d_s;
          i_req_ready = ~gnt_d_s;
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        mem_avalid = 1'b1;
        if (mem_aready) begin
          state_nxt_s = we_r ? ST_WDATA : ST_RDATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_WDATA: begin
        mem_wvalid = d_wvalid;
        d_wready   = mem_wready;
        mem_wdata  = d_wdata;
        mem_wstrb  = d_wstrb;
        mem_wlast  = (cnt_r == {LENW{1'b0}});
        if (wbeat_s && (cnt_r == {LENW{1'b0}})) begin
          state_nxt_s = ST_BRESP;
        end else begin
          state_nxt_s = ST_WDATA;
        end
      end
      ST_RDATA: begin
        // rlast ends the burst even if it arrives before the counted length.
        if (mem_rvalid && mem_rlast) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RDATA;
        end
      end
      ST_BRESP: begin
        d_bvalid = mem_bvalid;
        if (mem_bvalid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BRESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign rd_active_s = (state_r == ST_RDATA) & mem_rvalid;
  assign i_rvalid    = rd_active_s & (owner_r == OWN_I);
  assign d_rvalid    = rd_active_s & (owner_r == OWN_D);
  assign i_rlast     = i_rvalid & mem_rlast;
  assign d_rlast     = d_rvalid & mem_rlast;
  assign rdata       = mem_rdata;

  assign mem_we   = we_r;
  assign mem_addr = addr_r;
  assign mem_len  = len_r;

  // State, latched request fields and write beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_I;
      we_r    <= 1'b0;
      addr_r  <= '0;
      len_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        owner_r <= gnt_d_s;
        we_r    <= gnt_d_s & d_req_we;
        addr_r  <= gnt_d_s ? d_req_addr : i_req_addr;
        len_r   <= gnt_d_s ? d_req_len : i_req_len;
        cnt_r   <= gnt_d_s ? d_req_len : i_req_len;
      end else if (wbeat_s && (cnt_r != {LENW{1'b0}})) begin
        cnt_r <= cnt_r - LENW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule
